// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared opcodes, state encoding and ID/EX record for decode.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int unsigned c_reg_aw  = 3;
    localparam int unsigned c_instr_w = 16;

    localparam logic [4:0] c_op_ld    = 5'b10001;
    localparam logic [4:0] c_op_st    = 5'b10000;
    localparam logic [4:0] c_op_rtype = 5'b11011;
    localparam logic [4:0] c_op_nop   = 5'b00001;
    localparam logic [4:0] c_op_halt  = 5'b00000;

    localparam logic [2:0] c_pfx_alui = 3'b010;
    localparam logic [2:0] c_pfx_br   = 3'b011;

    localparam logic [c_instr_w-1:0] c_nop_instr = 16'h0800;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        IC_OTHER = 3'd0,
        IC_LD    = 3'd1,
        IC_ST    = 3'd2,
        IC_RTYPE = 3'd3,
        IC_ALUI  = 3'd4,
        IC_BR    = 3'd5,
        IC_HALT  = 3'd6
    } iclass_e;

    typedef struct packed {
        logic                valid;
        logic                halt;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic [c_reg_aw-1:0] rd;
        logic [15:0]         imm;
        logic [15:0]         pc2;
    } idex_ctrl_t;

    function automatic iclass_e classify(input logic [4:0] opcode);
        iclass_e cls;
        cls = IC_OTHER;
        if (opcode == c_op_ld)              cls = IC_LD;
        else if (opcode == c_op_st)         cls = IC_ST;
        else if (opcode == c_op_rtype)      cls = IC_RTYPE;
        else if (opcode == c_op_halt)       cls = IC_HALT;
        else if (opcode == c_op_nop)        cls = IC_OTHER;
        else if (opcode[4:2] == c_pfx_alui) cls = IC_ALUI;
        else if (opcode[4:2] == c_pfx_br)   cls = IC_BR;
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile8x16.sv
`default_nettype none
// ============================================================================
// Module      : regfile8x16
// Description : NREG x WIDTH register file, 2 async reads, 1 sync write with
//               same-cycle write-to-read bypass, async active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile8x16
    import decode_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_reg_aw-1:0] i_rd_addr_a,
    output logic [WIDTH-1:0]    o_rd_data_a,
    input  logic [c_reg_aw-1:0] i_rd_addr_b,
    output logic [WIDTH-1:0]    o_rd_data_b,
    input  logic                i_wr_en,
    input  logic [c_reg_aw-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]    i_wr_data
);

    logic [WIDTH-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The write-back value is forwarded so decode sees it in the same cycle.
    always_comb begin
        o_rd_data_a = r_mem[i_rd_addr_a];
        o_rd_data_b = r_mem[i_rd_addr_b];
        if (i_wr_en && (i_wr_addr == i_rd_addr_a)) o_rd_data_a = i_wr_data;
        if (i_wr_en && (i_wr_addr == i_rd_addr_b)) o_rd_data_b = i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
// Module      : decode
// Description : Instruction decode stage with register file, load-use stall,
//               flush handling, halt state and the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode
    import decode_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_instr_w-1:0] instr_IFID,
    input  logic [15:0]          PC2_IFID,
    input  logic                 halt_IFID,
    input  logic                 takeBranch_EXMEM,
    input  logic                 wrEn_MEMWB,
    input  logic [c_reg_aw-1:0]  wrReg_MEMWB,
    input  logic [WIDTH-1:0]     wrData_MEMWB,
    output logic                 stallCtrl,
    output logic [WIDTH-1:0]     A_IDEX,
    output logic [WIDTH-1:0]     B_IDEX,
    output logic [15:0]          imm_IDEX,
    output logic [15:0]          PC2_IDEX,
    output logic [c_reg_aw-1:0]  rd_IDEX,
    output logic                 memRead_IDEX,
    output logic                 memWrite_IDEX,
    output logic                 regWrite_IDEX,
    output logic                 halt_IDEX,
    output logic                 valid_IDEX
);

    state_e               r_state;
    state_e               w_state_next;
    idex_ctrl_t           r_idex;
    idex_ctrl_t           w_idex_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     w_a_next;
    logic [WIDTH-1:0]     w_b_next;

    logic [c_instr_w-1:0] w_instr;
    logic [4:0]           w_opcode;
    logic [c_reg_aw-1:0]  w_rs;
    logic [c_reg_aw-1:0]  w_rt;
    iclass_e              w_class;
    logic                 w_mem_read;
    logic                 w_mem_write;
    logic                 w_reg_write;
    logic [c_reg_aw-1:0]  w_rd;
    logic [15:0]          w_imm;
    logic                 w_is_halt;
    logic                 w_instr_valid;
    logic                 w_flush;
    logic                 w_stall;
    logic                 w_issue;
    logic [WIDTH-1:0]     w_rd_a;
    logic [WIDTH-1:0]     w_rd_b;

    // Once halted the fetched word is replaced by a NOP so it cannot leak in.
    assign w_instr  = (r_state == HALTED) ? c_nop_instr : instr_IFID;
    assign w_opcode = w_instr[15:11];
    assign w_rs     = w_instr[10:8];
    assign w_rt     = w_instr[7:5];
    assign w_class  = classify(w_opcode);

    always_comb begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_rd        = '0;
        w_imm       = '0;
        unique case (w_class)
            IC_LD: begin
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
                w_rd        = w_rt;
                w_imm       = {{11{w_instr[4]}}, w_instr[4:0]};
            end
            IC_ST: begin
                w_mem_write = 1'b1;
                w_imm       = {{11{w_instr[4]}}, w_instr[4:0]};
            end
            IC_RTYPE: begin
                w_reg_write = 1'b1;
                w_rd        = w_instr[4:2];
            end
            IC_ALUI: begin
                w_reg_write = 1'b1;
                w_rd        = w_rt;
                w_imm       = {{11{w_instr[4]}}, w_instr[4:0]};
            end
            IC_BR: begin
                w_imm = {{8{w_instr[7]}}, w_instr[7:0]};
            end
            default: begin
            end
        endcase
    end

    assign w_is_halt     = (w_class == IC_HALT) || halt_IFID;
    assign w_instr_valid = (r_state == RUN);
    assign w_flush       = takeBranch_EXMEM;

    // Load-use hazard against the load currently sitting in ID/EX.
    assign w_stall = w_instr_valid && !w_flush && r_idex.mem_read &&
                     ((r_idex.rd == w_rs) || (r_idex.rd == w_rt));
    assign w_issue = w_instr_valid && !w_flush && !w_stall;

    assign stallCtrl = w_stall;

    regfile8x16 #(
        .NREG  (NREG),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr_a (w_rs),
        .o_rd_data_a (w_rd_a),
        .i_rd_addr_b (w_rt),
        .o_rd_data_b (w_rd_b),
        .i_wr_en     (wrEn_MEMWB),
        .i_wr_addr   (wrReg_MEMWB),
        .i_wr_data   (wrData_MEMWB)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_flush) begin
            w_state_next = RUN;
        end else if (w_issue && w_is_halt) begin
            w_state_next = HALTED;
        end
    end

    // Anything not issued becomes an all-zero bubble.
    always_comb begin
        w_idex_next = '0;
        w_a_next    = '0;
        w_b_next    = '0;
        if (w_issue) begin
            w_idex_next.valid     = 1'b1;
            w_idex_next.halt      = w_is_halt;
            w_idex_next.mem_read  = w_mem_read;
            w_idex_next.mem_write = w_mem_write;
            w_idex_next.reg_write = w_reg_write;
            w_idex_next.rd        = w_rd;
            w_idex_next.imm       = w_imm;
            w_idex_next.pc2       = PC2_IFID;
            w_a_next              = w_rd_a;
            w_b_next              = w_rd_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idex <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            r_idex <= w_idex_next;
            r_a    <= w_a_next;
            r_b    <= w_b_next;
        end
    end

    assign A_IDEX        = r_a;
    assign B_IDEX        = r_b;
    assign imm_IDEX      = r_idex.imm;
    assign PC2_IDEX      = r_idex.pc2;
    assign rd_IDEX       = r_idex.rd;
    assign memRead_IDEX  = r_idex.mem_read;
    assign memWrite_IDEX = r_idex.mem_write;
    assign regWrite_IDEX = r_idex.reg_write;
    assign halt_IDEX     = r_idex.halt;
    assign valid_IDEX    = r_idex.valid;

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode
// Description : Scoreboard bench for decode: directed scenarios plus random
//               traffic checked against a behavioural pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_IFID;
    logic [15:0] PC2_IFID;
    logic        halt_IFID;
    logic        takeBranch_EXMEM;
    logic        wrEn_MEMWB;
    logic [2:0]  wrReg_MEMWB;
    logic [15:0] wrData_MEMWB;
    logic        stallCtrl;
    logic [15:0] A_IDEX, B_IDEX, imm_IDEX, PC2_IDEX;
    logic [2:0]  rd_IDEX;
    logic        memRead_IDEX, memWrite_IDEX, regWrite_IDEX, halt_IDEX, valid_IDEX;

    always #5 clk = ~clk;

    decode #(.NREG(8), .WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_IFID       (instr_IFID),
        .PC2_IFID         (PC2_IFID),
        .halt_IFID        (halt_IFID),
        .takeBranch_EXMEM (takeBranch_EXMEM),
        .wrEn_MEMWB       (wrEn_MEMWB),
        .wrReg_MEMWB      (wrReg_MEMWB),
        .wrData_MEMWB     (wrData_MEMWB),
        .stallCtrl        (stallCtrl),
        .A_IDEX           (A_IDEX),
        .B_IDEX           (B_IDEX),
        .imm_IDEX         (imm_IDEX),
        .PC2_IDEX         (PC2_IDEX),
        .rd_IDEX          (rd_IDEX),
        .memRead_IDEX     (memRead_IDEX),
        .memWrite_IDEX    (memWrite_IDEX),
        .regWrite_IDEX    (regWrite_IDEX),
        .halt_IDEX        (halt_IDEX),
        .valid_IDEX       (valid_IDEX)
    );

    typedef struct {
        logic        valid, halt, mem_read, mem_write, reg_write;
        logic [2:0]  rd;
        logic [15:0] a, b, imm, pc2;
    } idex_t;

    idex_t       out_q[$];
    logic        stall_q[$];
    idex_t       mon_e;
    logic        mon_s;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] m_regs [8];
    logic        m_halted;
    idex_t       m_prev;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_halted = 1'b0;
        m_prev   = '{default: '0};
    endtask

    // One pipeline cycle: apply inputs, predict, then step past the next edge.
    task automatic drive(input logic [15:0] ins, input logic [15:0] pc2, input logic hf,
                         input logic tb, input logic we, input logic [2:0] wr,
                         input logic [15:0] wd);
        idex_t       e;
        logic [4:0]  op;
        logic [2:0]  rs, rt;
        logic        st;
        instr_IFID       = ins;
        PC2_IFID         = pc2;
        halt_IFID        = hf;
        takeBranch_EXMEM = tb;
        wrEn_MEMWB       = we;
        wrReg_MEMWB      = wr;
        wrData_MEMWB     = wd;
        op = ins[15:11];
        rs = ins[10:8];
        rt = ins[7:5];
        st = !tb && !m_halted && m_prev.mem_read && (m_prev.rd == rs || m_prev.rd == rt);
        e  = '{default: '0};
        if (!tb && !m_halted && !st) begin
            e.valid = 1'b1;
            e.a     = (we && wr == rs) ? wd : m_regs[rs];
            e.b     = (we && wr == rt) ? wd : m_regs[rt];
            e.pc2   = pc2;
            e.halt  = (op == 5'b00000) || hf;
            if (op == 5'b10001) begin
                e.mem_read = 1'b1; e.reg_write = 1'b1; e.rd = rt;
                e.imm = {{11{ins[4]}}, ins[4:0]};
            end else if (op == 5'b10000) begin
                e.mem_write = 1'b1;
                e.imm = {{11{ins[4]}}, ins[4:0]};
            end else if (op == 5'b11011) begin
                e.reg_write = 1'b1; e.rd = ins[4:2];
            end else if (op[4:2] == 3'b010) begin
                e.reg_write = 1'b1; e.rd = rt;
                e.imm = {{11{ins[4]}}, ins[4:0]};
            end else if (op[4:2] == 3'b011) begin
                e.imm = {{8{ins[7]}}, ins[7:0]};
            end
        end
        if (tb) m_halted = 1'b0;
        else if (e.valid && e.halt) m_halted = 1'b1;
        m_prev = e;
        if (we) m_regs[wr] = wd;
        stall_q.push_back(st);
        out_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (stall_q.size() != 0) begin
                mon_s = stall_q.pop_front();
                check("stallCtrl", 16'(stallCtrl), 16'(mon_s));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_q.size() != 0) begin
                mon_e = out_q.pop_front();
                check("valid_IDEX", 16'(valid_IDEX), 16'(mon_e.valid));
                check("halt_IDEX", 16'(halt_IDEX), 16'(mon_e.halt));
                check("memRead_IDEX", 16'(memRead_IDEX), 16'(mon_e.mem_read));
                check("memWrite_IDEX", 16'(memWrite_IDEX), 16'(mon_e.mem_write));
                check("regWrite_IDEX", 16'(regWrite_IDEX), 16'(mon_e.reg_write));
                if (mon_e.reg_write || mon_e.mem_read) check("rd_IDEX", 16'(rd_IDEX), 16'(mon_e.rd));
                if (mon_e.valid) begin
                    check("A_IDEX", A_IDEX, mon_e.a);
                    check("B_IDEX", B_IDEX, mon_e.b);
                end
                check("imm_IDEX", imm_IDEX, mon_e.imm);
                check("PC2_IDEX", PC2_IDEX, mon_e.pc2);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_A"}, A_IDEX, 16'h0000);
        check({tag, "_B"}, B_IDEX, 16'h0000);
        check({tag, "_imm"}, imm_IDEX, 16'h0000);
        check({tag, "_pc2"}, PC2_IDEX, 16'h0000);
        check({tag, "_ctrl"}, 16'({rd_IDEX, memRead_IDEX, memWrite_IDEX, regWrite_IDEX,
                                   halt_IDEX, valid_IDEX}), 16'h0000);
        check({tag, "_stall"}, 16'(stallCtrl), 16'h0000);
    endtask

    localparam logic [15:0] LD_R4  = 16'b10001_000_100_00011;
    localparam logic [15:0] ADD_R4 = 16'b11011_100_001_011_00;
    localparam logic [15:0] NOPI   = 16'h0800;

    initial begin
        logic [31:0] r;
        logic [4:0]  op;
        rst = 1'b0;
        instr_IFID = 16'h0; PC2_IFID = 16'h0; halt_IFID = 1'b0; takeBranch_EXMEM = 1'b0;
        wrEn_MEMWB = 1'b0; wrReg_MEMWB = 3'd0; wrData_MEMWB = 16'h0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;

        // R3 write then R-type reading it
        drive(NOPI, 16'h0002, 0, 0, 1, 3'd3, 16'h1234);
        drive(16'b11011_011_001_010_00, 16'h0004, 0, 0, 0, 3'd0, 16'h0);
        // load-use stall, then the ADD re-decodes with a forwarded load value
        drive(LD_R4, 16'h0006, 0, 0, 0, 3'd0, 16'h0);
        drive(ADD_R4, 16'h0008, 0, 0, 0, 3'd0, 16'h0);
        drive(ADD_R4, 16'h0008, 0, 0, 1, 3'd4, 16'hCAFE);
        // same-cycle bypass
        drive(16'b01000_101_000_00111, 16'h000A, 0, 0, 1, 3'd5, 16'hBEEF);
        // halt, ignored instructions, flush back to RUN
        drive(16'h0000, 16'h000C, 0, 0, 0, 3'd0, 16'h0);
        drive(16'b01000_001_010_00101, 16'h000E, 0, 0, 1, 3'd6, 16'h5555);
        drive(16'b10000_001_010_11111, 16'h0010, 0, 0, 0, 3'd0, 16'h0);
        drive(NOPI, 16'h0012, 0, 1, 0, 3'd0, 16'h0);
        drive(16'b01100_001_110_00000, 16'h0014, 0, 0, 0, 3'd0, 16'h0);
        // halt via fetch flag
        drive(NOPI, 16'h0016, 1, 0, 0, 3'd0, 16'h0);
        drive(ADD_R4, 16'h0018, 0, 1, 0, 3'd0, 16'h0);
        // stall and flush together
        drive(LD_R4, 16'h001A, 0, 0, 0, 3'd0, 16'h0);
        drive(ADD_R4, 16'h001C, 0, 1, 0, 3'd0, 16'h0);
        drive(ADD_R4, 16'h001E, 0, 0, 0, 3'd0, 16'h0);

        // reset asserted mid-stall
        drive(LD_R4, 16'h0020, 0, 0, 0, 3'd0, 16'h0);
        instr_IFID = ADD_R4;
        #2;
        check("stall_before_rst", 16'(stallCtrl), 16'h0001);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        out_q.delete();
        stall_q.delete();
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive({5'b11011, 3'(i), 3'(i + 1), 5'b00000}, 16'(i), 0, 0, 0, 3'd0, 16'h0);
        end

        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            case ($urandom_range(0, 9))
                0:       op = 5'b10001;
                1:       op = 5'b10000;
                2, 3:    op = 5'b11011;
                4:       op = {3'b010, 2'($urandom_range(0, 3))};
                5:       op = {3'b011, 2'($urandom_range(0, 3))};
                6:       op = 5'b00001;
                7:       op = ($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom());
                default: op = 5'($urandom());
            endcase
            drive({op, r[10:0]}, 16'($urandom()), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom()));
        end

        @(posedge clk); @(posedge clk); #2;
        check("queue_drain", 16'(out_q.size() + stall_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
